// File: rtl/async_operator_q_if.sv
// async_operator_q_if -- bundle of the operand-side and consumer-side handshake
// signals of async_operator_q.
//
// Signals (named from the operator's point of view):
//   req_l [input_size]             operator -> producers : operand request
//   ack_l [input_size]             producers -> operator : operand acknowledge (din valid)
//   din   [data_width*input_size]  producers -> operator : operand i at [data_width*i +: data_width]
//   req_r [output_size]            consumers -> operator : consumer request
//   ack_r [output_size]            operator -> consumers : one-cycle acknowledge
//   dout  [data_width]             operator -> consumers : buffer head value (0 when empty)
//   count [clog2(depth+1)]         operator -> consumers : buffer occupancy
//
// Modports: master = the operator, slave = the producer/consumer environment.
interface async_operator_q_if #(
    parameter int data_width  = 32,
    parameter int input_size  = 1,
    parameter int output_size = 1,
    parameter int depth       = 2
);
    localparam int cnt_w = $clog2(depth + 1);

    logic [input_size-1:0]            req_l;
    logic [input_size-1:0]            ack_l;
    logic [data_width*input_size-1:0] din;
    logic [output_size-1:0]           req_r;
    logic [output_size-1:0]           ack_r;
    logic [data_width-1:0]            dout;
    logic [cnt_w-1:0]                 count;

    modport master (
        output req_l, ack_r, dout, count,
        input  ack_l, din, req_r
    );

    modport slave (
        input  req_l, ack_r, dout, count,
        output ack_l, din, req_r
    );
endinterface

// File: rtl/async_operator_q.sv
// async_operator_q -- collects one operand per input channel, combines them with
// a compile-time selected operation and queues the result in a small buffer
// that several consumers read independently. The head entry is released only
// after every consumer has been acknowledged once.
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-low reset
//   bus  : async_operator_q_if.master (req_l/ack_l/din operand side,
//          req_r/ack_r/dout/count consumer side)
//
// Handshake rules:
//   Operand side : the operator raises req_l[i] while it has no operand i and
//   holds it until the producer answers with ack_l[i]; din slice i is captured
//   on the edge where ack_l[i] is high.
//   Consumer side: a consumer holds req_r[j]; the operator answers with a
//   one-cycle ack_r[j] pulse while dout shows the head entry. Each consumer is
//   acknowledged once per entry; the entry is popped on the edge after all
//   consumers have been acknowledged and no ack_r pulse is in flight.
module async_operator_q #(
    parameter int    data_width  = 32,
    parameter string op          = "reg",
    parameter int    immediate   = 0,
    parameter int    input_size  = 1,
    parameter int    output_size = 1,
    parameter int    depth       = 2
) (
    input logic                clk,
    input logic                rst,
    async_operator_q_if.master bus
);
    localparam int cnt_w = $clog2(depth + 1);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [data_width-1:0] imm_w    = data_width'(immediate);
    localparam logic [ptr_w-1:0]      last_ptr = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0]      full_cnt = cnt_w'(depth);

    localparam int OP_PASS = 0;
    localparam int OP_ADDI = 1;
    localparam int OP_SUBI = 2;
    localparam int OP_MULI = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_MUL  = 6;
    localparam int OP_MIN  = 7;
    localparam int OP_MAX  = 8;
    localparam int OP_AND  = 9;
    localparam int OP_OR   = 10;
    localparam int OP_XOR  = 11;

    // reg / in / out and any unknown name fall back to pass-through.
    localparam int op_sel = (op == "addi") ? OP_ADDI :
                            (op == "subi") ? OP_SUBI :
                            (op == "muli") ? OP_MULI :
                            (op == "add")  ? OP_ADD  :
                            (op == "sub")  ? OP_SUB  :
                            (op == "mul")  ? OP_MUL  :
                            (op == "min")  ? OP_MIN  :
                            (op == "max")  ? OP_MAX  :
                            (op == "and")  ? OP_AND  :
                            (op == "or")   ? OP_OR   :
                            (op == "xor")  ? OP_XOR  : OP_PASS;

    logic [data_width-1:0]  opnd [input_size];
    logic [input_size-1:0]  has;
    logic [input_size-1:0]  req_q;
    logic                   armed;
    logic [output_size-1:0] taken;
    logic [output_size-1:0] ack_q;
    logic [data_width-1:0]  mem [depth];
    logic [ptr_w-1:0]       wptr;
    logic [ptr_w-1:0]       rptr;
    logic [cnt_w-1:0]       count_q;
    logic [data_width-1:0]  result;
    logic                   fire;
    logic                   pop;
    logic [output_size-1:0] grant;

    // Fire uses the pre-edge count, so a full buffer stalls even if it pops now.
    assign fire = (&has) && (count_q < full_cnt);
    assign pop  = (&taken) && !(|ack_q);

    always_comb begin
        grant = '0;
        for (int j = 0; j < output_size; j++) begin
            grant[j] = bus.req_r[j] && !ack_q[j] && (count_q != '0) && !taken[j];
        end
    end

    // Arithmetic wraps modulo 2^data_width; products keep the low bits.
    always_comb begin
        result = opnd[0];
        case (op_sel)
            OP_ADDI: result = opnd[0] + imm_w;
            OP_SUBI: result = opnd[0] - imm_w;
            OP_MULI: result = opnd[0] * imm_w;
            default: begin
                for (int i = 1; i < input_size; i++) begin
                    case (op_sel)
                        OP_ADD:  result = result + opnd[i];
                        OP_SUB:  result = result - opnd[i];
                        OP_MUL:  result = result * opnd[i];
                        OP_MIN:  result = (opnd[i] < result) ? opnd[i] : result;
                        OP_MAX:  result = (opnd[i] > result) ? opnd[i] : result;
                        OP_AND:  result = result & opnd[i];
                        OP_OR:   result = result | opnd[i];
                        OP_XOR:  result = result ^ opnd[i];
                        default: result = result;
                    endcase
                end
            end
        endcase
    end

    // Operand side. 'armed' delays the first request to the second edge after
    // reset release, giving producers one full cycle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
            has   <= '0;
            req_q <= '0;
            for (int i = 0; i < input_size; i++) begin
                opnd[i] <= '0;
            end
        end else begin
            armed <= 1'b1;
            for (int i = 0; i < input_size; i++) begin
                if (bus.ack_l[i]) begin
                    opnd[i]  <= bus.din[data_width*i +: data_width];
                    has[i]   <= 1'b1;
                    req_q[i] <= 1'b0;
                end else begin
                    if (fire) begin
                        has[i] <= 1'b0;
                    end
                    if (armed && !has[i] && !req_q[i]) begin
                        req_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Result buffer storage needs no reset: dout is gated by count.
    always_ff @(posedge clk) begin
        if (fire) begin
            mem[wptr] <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            taken   <= '0;
            ack_q   <= '0;
        end else begin
            if (fire) begin
                wptr <= (wptr == last_ptr) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == last_ptr) ? '0 : rptr + 1'b1;
            end
            case ({fire, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ack_q <= grant;
            taken <= pop ? '0 : (taken | grant);
        end
    end

    assign bus.req_l = req_q;
    assign bus.ack_r = ack_q;
    assign bus.count = count_q;
    assign bus.dout  = (count_q != '0) ? mem[rptr] : '0;
endmodule

// File: tb/tb_async_operator_q.sv
// tb_async_operator_q -- directed bench for async_operator_q. Instances:
//   a_*  : add, 32-bit, 2 operands, 2 consumers, depth 2 (handshake, stall, pop, reset)
//   m_*  : mul, 8-bit, 2 operands, 1 consumer
//   g_*  : min/max/sub/xor/subi(10), 32-bit, 3 operands, 1 consumer, shared stimulus
// Producers answer combinationally: ack_l = req_l & <auto mask>.
module tb_async_operator_q;
    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [1:0]  a_auto;
    logic [1:0]  m_auto;
    logic [2:0]  g_auto;
    logic [95:0] g_din;
    logic        g_req_r;

    async_operator_q_if #(.data_width(32), .input_size(2), .output_size(2), .depth(2)) a_if ();
    async_operator_q_if #(.data_width(8),  .input_size(2), .output_size(1), .depth(2)) m_if ();
    async_operator_q_if #(.data_width(32), .input_size(3), .output_size(1), .depth(2)) gmin_if ();
    async_operator_q_if #(.data_width(32), .input_size(3), .output_size(1), .depth(2)) gmax_if ();
    async_operator_q_if #(.data_width(32), .input_size(3), .output_size(1), .depth(2)) gsub_if ();
    async_operator_q_if #(.data_width(32), .input_size(3), .output_size(1), .depth(2)) gxor_if ();
    async_operator_q_if #(.data_width(32), .input_size(3), .output_size(1), .depth(2)) gsbi_if ();

    async_operator_q #(.data_width(32), .op("add"), .immediate(0), .input_size(2), .output_size(2), .depth(2))
        u_add (.clk(clk), .rst(rst), .bus(a_if));
    async_operator_q #(.data_width(8), .op("mul"), .immediate(0), .input_size(2), .output_size(1), .depth(2))
        u_mul (.clk(clk), .rst(rst), .bus(m_if));
    async_operator_q #(.data_width(32), .op("min"), .immediate(0), .input_size(3), .output_size(1), .depth(2))
        u_min (.clk(clk), .rst(rst), .bus(gmin_if));
    async_operator_q #(.data_width(32), .op("max"), .immediate(0), .input_size(3), .output_size(1), .depth(2))
        u_max (.clk(clk), .rst(rst), .bus(gmax_if));
    async_operator_q #(.data_width(32), .op("sub"), .immediate(0), .input_size(3), .output_size(1), .depth(2))
        u_sub (.clk(clk), .rst(rst), .bus(gsub_if));
    async_operator_q #(.data_width(32), .op("xor"), .immediate(0), .input_size(3), .output_size(1), .depth(2))
        u_xor (.clk(clk), .rst(rst), .bus(gxor_if));
    async_operator_q #(.data_width(32), .op("subi"), .immediate(10), .input_size(3), .output_size(1), .depth(2))
        u_subi (.clk(clk), .rst(rst), .bus(gsbi_if));

    assign a_if.ack_l    = a_if.req_l & a_auto;
    assign m_if.ack_l    = m_if.req_l & m_auto;
    assign gmin_if.ack_l = gmin_if.req_l & g_auto;
    assign gmax_if.ack_l = gmax_if.req_l & g_auto;
    assign gsub_if.ack_l = gsub_if.req_l & g_auto;
    assign gxor_if.ack_l = gxor_if.req_l & g_auto;
    assign gsbi_if.ack_l = gsbi_if.req_l & g_auto;
    assign gmin_if.din   = g_din;
    assign gmax_if.din   = g_din;
    assign gsub_if.din   = g_din;
    assign gxor_if.din   = g_din;
    assign gsbi_if.din   = g_din;
    assign gmin_if.req_r = g_req_r;
    assign gmax_if.req_r = g_req_r;
    assign gsub_if.req_r = g_req_r;
    assign gxor_if.req_r = g_req_r;
    assign gsbi_if.req_r = g_req_r;

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve both consumers of the add instance for one entry and expect the pop.
    task automatic serve_a(input logic [31:0] head, input logic [31:0] next_count,
                           input logic [31:0] next_head);
        a_if.req_r = 2'b11;
        tick(1);
        check("serve_ack", a_if.ack_r, 2'b11);
        check("serve_dout", a_if.dout, head);
        a_if.req_r = 2'b00;
        tick(2);
        check("serve_count", a_if.count, next_count);
        check("serve_next", a_if.dout, next_head);
    endtask

    initial begin
        rst       = 1'b0;
        a_auto    = 2'b11;
        a_if.din  = {32'd7, 32'd5};
        a_if.req_r = 2'b00;
        m_auto    = 2'b11;
        m_if.din  = {8'd17, 8'd16};
        m_if.req_r = 1'b0;
        g_auto    = 3'b111;
        g_din     = {32'd200, 32'd3, 32'd9};
        g_req_r   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_l", a_if.req_l, 2'b00);
        check("rst_ack_r", a_if.ack_r, 2'b00);
        check("rst_count", a_if.count, 0);
        check("rst_dout", a_if.dout, 0);
        check("rst_m_dout", m_if.dout, 0);
        rst = 1'b1;

        tick(1);                                   // edge 1: no request yet
        check("req_edge1", a_if.req_l, 2'b00);
        tick(1);                                   // edge 2: requests rise
        check("req_edge2", a_if.req_l, 2'b11);
        check("g_req_edge2", gmin_if.req_l, 3'b111);
        tick(1);                                   // edge 3: operands captured
        check("req_clear", a_if.req_l, 2'b00);
        a_auto = 2'b00;
        g_din  = {32'd5, 32'd6, 32'd1};
        m_if.din = {8'd255, 8'd255};

        tick(1);                                   // edge 4: fire
        check("add_count", a_if.count, 1);
        check("add_dout", a_if.dout, 32'd12);
        check("mul_dout", m_if.dout, 32'h10);      // 16*17 = 272 mod 256
        check("mul_count", m_if.count, 1);
        check("min_dout", gmin_if.dout, 32'd3);
        check("max_dout", gmax_if.dout, 32'd200);
        check("sub_dout", gsub_if.dout, 32'hFFFF_FF3E); // 9-3-200 = -194
        check("xor_dout", gxor_if.dout, 32'd194);  // 9^3^200
        check("subi_dout", gsbi_if.dout, 32'hFFFF_FFFF); // 9-10
        a_if.req_r = 2'b11;

        tick(1);
        check("a_ack_pulse", a_if.ack_r, 2'b11);
        check("a_ack_dout", a_if.dout, 32'd12);
        tick(1);
        check("a_ack_end", a_if.ack_r, 2'b00);
        check("a_no_early_pop", a_if.count, 1);
        tick(1);                                   // edge 7: pop
        check("a_pop_count", a_if.count, 0);
        check("a_empty_dout", a_if.dout, 0);
        a_if.req_r = 2'b00;
        a_if.din   = {32'd23, 32'd100};
        a_auto     = 2'b11;
        g_req_r    = 1'b1;
        m_if.req_r = 1'b1;

        tick(1);                                   // edge 8
        check("g_ack", gmin_if.ack_r, 1'b1);
        check("g_ack_dout", gmin_if.dout, 32'd3);
        check("m_ack", m_if.ack_r, 1'b1);
        check("m_ack_dout", m_if.dout, 32'h10);
        a_auto     = 2'b00;
        a_if.req_r = 2'b01;
        g_req_r    = 1'b0;
        m_if.req_r = 1'b0;

        tick(1);                                   // edge 9: add fires, no ack while empty
        check("a2_count", a_if.count, 1);
        check("a2_dout", a_if.dout, 32'd123);
        check("a2_no_ack", a_if.ack_r, 2'b00);
        tick(1);                                   // edge 10
        check("a2_ack0", a_if.ack_r, 2'b01);
        check("a2_ack0_dout", a_if.dout, 32'd123);
        check("min2_dout", gmin_if.dout, 32'd1);
        check("max2_dout", gmax_if.dout, 32'd6);
        check("sub2_dout", gsub_if.dout, 32'hFFFF_FFF6); // 1-6-5
        check("xor2_dout", gxor_if.dout, 32'd2);   // 1^6^5
        check("subi2_dout", gsbi_if.dout, 32'hFFFF_FFF7); // 1-10
        check("mul2_dout", m_if.dout, 32'h01);     // 255*255 mod 256

        for (int k = 0; k < 4; k++) begin          // consumer 1 still idle
            tick(1);
            check("a2_hold_ack", a_if.ack_r, 2'b00);
            check("a2_hold_count", a_if.count, 1);
        end
        a_if.req_r = 2'b11;
        tick(1);                                   // edge 15: only consumer 1
        check("a2_ack1", a_if.ack_r, 2'b10);
        check("a2_ack1_dout", a_if.dout, 32'd123);
        tick(1);
        check("a2_wait_pop", a_if.count, 1);
        tick(1);                                   // edge 17: pop
        check("a2_pop", a_if.count, 0);
        a_if.req_r = 2'b00;

        // Fill to depth with distinct entries 1, 2, 3; third set stays held.
        a_if.din = {32'd0, 32'd1};
        a_auto   = 2'b11;
        tick(1);
        a_if.din = {32'd0, 32'd2};
        tick(3);
        a_if.din = {32'd0, 32'd3};
        tick(3);
        a_if.din = {32'd10, 32'd20};
        tick(5);                                   // edge 29
        check("full_count", a_if.count, 2);
        check("full_req_low", a_if.req_l, 2'b00);
        check("full_head", a_if.dout, 32'd1);
        a_if.req_r = 2'b11;
        tick(1);
        check("full_ack", a_if.ack_r, 2'b11);
        a_if.req_r = 2'b00;
        tick(1);
        check("full_no_pop", a_if.count, 2);
        tick(1);                                   // edge 32: pop, fire stalled
        check("full_pop_count", a_if.count, 1);
        check("full_pop_head", a_if.dout, 32'd2);
        tick(1);                                   // edge 33: released firing
        check("refire_count", a_if.count, 2);
        check("refire_req", a_if.req_l, 2'b00);
        tick(1);
        check("rereq", a_if.req_l, 2'b11);
        a_auto = 2'b00;
        serve_a(32'd2, 32'd1, 32'd3);
        serve_a(32'd3, 32'd0, 32'd0);

        // Reset while full with one operand held.
        a_if.din = {32'd0, 32'd9};
        a_auto   = 2'b11;
        tick(5);
        check("pre_rst_count", a_if.count, 2);
        a_auto = 2'b01;
        tick(2);
        check("pre_rst_req", a_if.req_l, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req_l", a_if.req_l, 2'b00);
        check("arst_ack_r", a_if.ack_r, 2'b00);
        check("arst_count", a_if.count, 0);
        check("arst_dout", a_if.dout, 0);
        check("arst_g_count", gmin_if.count, 0);
        a_if.din = {32'd40, 32'd2};
        a_auto   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1);
        check("rel_req_edge1", a_if.req_l, 2'b00);
        tick(1);
        check("rel_req_edge2", a_if.req_l, 2'b11);
        tick(2);
        check("rel_count", a_if.count, 1);
        check("rel_dout", a_if.dout, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
